// File: rtl/itof.sv
// Signed 32-bit integer to IEEE-754 single converter, three register stages.
// Define ITOF_STALL_EN to add a stall input that freezes the whole pipeline.
module itof #(
  parameter bit TRUNC = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stage1_valid,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic        valid
`ifdef ITOF_STALL_EN
  ,
  input  logic        stall
`endif
);

  logic adv;
`ifdef ITOF_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  // Stage 1: sign/magnitude split
  logic        s1_valid_q;
  logic        s1_sign_q, s1_sign_d;
  logic        s1_zero_q, s1_zero_d;
  logic [31:0] s1_mag_q, s1_mag_d;

  always_comb begin
    s1_sign_d = x[31];
    s1_mag_d  = x[31] ? (~x + 32'd1) : x;
    s1_zero_d = (x == '0);
  end

  // Stage 2: normalise
  logic        s2_valid_q;
  logic        s2_sign_q, s2_zero_q;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [22:0] s2_man_q, s2_man_d;
  logic        s2_g_q, s2_g_d;
  logic        s2_st_q, s2_st_d;
  logic [4:0]  lz;
  logic [31:0] norm;

  always_comb begin
    lz = 5'd31;
    // Ascending scan: the highest set bit is the last to write lz.
    for (int unsigned i = 0; i < 32; i++) begin
      if (s1_mag_q[i]) lz = 5'(31 - i);
    end
    norm     = s1_mag_q << lz;
    s2_exp_d = 8'd158 - {3'd0, lz};
    s2_man_d = norm[30:8];
    s2_g_d   = norm[7];
    s2_st_d  = |norm[6:0];
  end

  // Stage 3: round and pack
  logic        rnd;
  logic [23:0] man_sum;
  logic [7:0]  exp_r;
  logic [31:0] y_d;

  always_comb begin
    rnd     = TRUNC ? 1'b0 : (s2_g_q & (s2_st_q | s2_man_q[0]));
    man_sum = {1'b0, s2_man_q} + {23'd0, rnd};
    exp_r   = man_sum[23] ? (s2_exp_q + 8'd1) : s2_exp_q;
    y_d     = s2_zero_q ? '0 : {s2_sign_q, exp_r, man_sum[22:0]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_g_q     <= 1'b0;
      s2_st_q    <= 1'b0;
      valid      <= 1'b0;
      y          <= '0;
    end else if (adv) begin
      s1_valid_q <= stage1_valid;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_zero_q  <= s1_zero_q;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s2_g_q     <= s2_g_d;
      s2_st_q    <= s2_st_d;
      valid      <= s2_valid_q;
      y          <= y_d;
    end
  end

endmodule

// File: tb/tb_itof.sv
// Directed bench for itof: a round-to-nearest and a truncating instance share inputs.
module tb_itof;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stage1_valid;
  logic [31:0] x;
  logic [31:0] y, y_t;
  logic        valid, valid_t;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  logic        pv [3];
  logic [31:0] py [3];
  logic [31:0] pt [3];

  always #5 clk = ~clk;

  itof #(.TRUNC(1'b0)) u_rne (
    .clk(clk), .rstn(rstn), .stage1_valid(stage1_valid), .x(x),
    .y(y), .valid(valid)
`ifdef ITOF_STALL_EN
    , .stall(stall)
`endif
  );

  itof #(.TRUNC(1'b1)) u_trunc (
    .clk(clk), .rstn(rstn), .stage1_valid(stage1_valid), .x(x),
    .y(y_t), .valid(valid_t)
`ifdef ITOF_STALL_EN
    , .stall(stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, " valid"}, {31'd0, valid}, {31'd0, pv[2]});
    chk({tag, " valid_t"}, {31'd0, valid_t}, {31'd0, pv[2]});
    if (pv[2]) begin
      chk({tag, " y"}, y, py[2]);
      chk({tag, " y_trunc"}, y_t, pt[2]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; py[i] = '0; pt[i] = '0;
    end
  endtask

  task automatic step(input string tag, input logic [31:0] xi, input logic vi,
                      input logic [31:0] ey, input logic [31:0] et);
    x = xi;
    stage1_valid = vi;
    @(posedge clk); #1;
    pv[2] = pv[1]; py[2] = py[1]; pt[2] = pt[1];
    pv[1] = pv[0]; py[1] = py[0]; pt[1] = pt[0];
    pv[0] = vi;    py[0] = ey;    pt[0] = et;
    check_out(tag);
  endtask

  task automatic reset_edge(input string tag);
    rstn = 1'b0;
    @(posedge clk); #1;
    clear_model();
    chk({tag, " rst valid"}, {31'd0, valid}, 32'd0);
    chk({tag, " rst y"}, y, 32'd0);
    chk({tag, " rst y_trunc"}, y_t, 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; x = '0; stage1_valid = 1'b0;
    clear_model();
    @(posedge clk); #1;
    reset_edge("init");

    // back-to-back basics
    step("x=1",  32'd1,        1'b1, 32'h3F800000, 32'h3F800000);
    step("x=-1", 32'hFFFFFFFF, 1'b1, 32'hBF800000, 32'hBF800000);
    step("x=5",  32'd5,        1'b1, 32'h40A00000, 32'h40A00000);
    // extremes and carry
    step("x=0",    32'h00000000, 1'b1, 32'h00000000, 32'h00000000);
    step("x=min",  32'h80000000, 1'b1, 32'hCF000000, 32'hCF000000);
    step("x=max",  32'h7FFFFFFF, 1'b1, 32'h4F000000, 32'h4EFFFFFF);
    // rounding ties
    step("2^24+1", 32'd16777217, 1'b1, 32'h4B800000, 32'h4B800000);
    step("2^24+3", 32'd16777219, 1'b1, 32'h4B800002, 32'h4B800001);
    step("2^24+5", 32'd16777221, 1'b1, 32'h4B800002, 32'h4B800002);
    step("-2^24-1", 32'hFEFFFFFF, 1'b1, 32'hCB800000, 32'hCB800000);
    // valid pattern 1,1,0,1,0,1,1
    step("p2",   32'd2,        1'b1, 32'h40000000, 32'h40000000);
    step("p3",   32'd3,        1'b1, 32'h40400000, 32'h40400000);
    step("p7",   32'd7,        1'b0, 32'h40E00000, 32'h40E00000);
    step("p10",  32'd10,       1'b1, 32'h41200000, 32'h41200000);
    step("p11",  32'd11,       1'b0, 32'h41300000, 32'h41300000);
    step("p-2",  32'hFFFFFFFE, 1'b1, 32'hC0000000, 32'hC0000000);
    step("p100", 32'd100,      1'b1, 32'h42C80000, 32'h42C80000);
    step("d0", 32'd1000, 1'b1, 32'h447A0000, 32'h447A0000);
    step("d1", 32'd0, 1'b0, 32'd0, 32'd0);
    step("d2", 32'd0, 1'b0, 32'd0, 32'd0);
    step("d3", 32'd0, 1'b0, 32'd0, 32'd0);

    // reset with three operands in flight
    step("f1", 32'd1, 1'b1, 32'h3F800000, 32'h3F800000);
    step("f2", 32'd2, 1'b1, 32'h40000000, 32'h40000000);
    x = 32'd3; stage1_valid = 1'b1;
    reset_edge("flight");
    step("after1", 32'd0, 1'b0, 32'd0, 32'd0);
    step("after2", 32'd0, 1'b0, 32'd0, 32'd0);
    step("after3", 32'd0, 1'b0, 32'd0, 32'd0);
    step("after4", 32'd5, 1'b1, 32'h40A00000, 32'h40A00000);
    step("after5", 32'd0, 1'b0, 32'd0, 32'd0);
    step("after6", 32'd0, 1'b0, 32'd0, 32'd0);

`ifdef ITOF_STALL_EN
    step("s1", 32'd1,  1'b1, 32'h3F800000, 32'h3F800000);
    step("s2", 32'd2,  1'b1, 32'h40000000, 32'h40000000);
    step("s3", 32'd3,  1'b1, 32'h40400000, 32'h40400000);
    x = 32'd10; stage1_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stall = 1'b1;
      @(posedge clk); #1;
      check_out("stalled");
    end
    stall = 1'b0;
    step("s10", 32'd10, 1'b1, 32'h41200000, 32'h41200000);
    step("sd1", 32'd0, 1'b0, 32'd0, 32'd0);
    step("sd2", 32'd0, 1'b0, 32'd0, 32'd0);
    step("sd3", 32'd0, 1'b0, 32'd0, 32'd0);
    step("sr1", 32'd5, 1'b1, 32'h40A00000, 32'h40A00000);
    step("sr2", 32'd5, 1'b1, 32'h40A00000, 32'h40A00000);
    step("sr3", 32'd5, 1'b1, 32'h40A00000, 32'h40A00000);
    stall = 1'b1;
    reset_edge("stall+rst");
    stall = 1'b0;
    step("sr4", 32'd0, 1'b0, 32'd0, 32'd0);
    step("sr5", 32'd0, 1'b0, 32'd0, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
